hub75_scan_controller: RTL and testbench

Sequencer for one rotational slice of the HUB75 panel. On each new `dtheta` it walks all `SCAN_RATE` row-pair addresses. For each row it requests column data from the frame manager, hands it to the HUB75 shifter, then blanks, latches and lights the panel for a fixed on-time. It sits between `detect_to_theta`/`frame_manager` and `hub75_output`, and owns `hub75_addr`, latch and output-enable timing.

---
 rtl/hub75_scan_controller.sv | 192 +++++++++++++++++++
 tb/tb_hub75_scan_controller.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/hub75_scan_controller.sv
// Row sequencer for one rotational slice of a HUB75 panel: fetch, shift,
// blank, latch and light each row-pair address in turn for a given theta.
module hub75_scan_controller #(
    parameter  int ROTATIONAL_RES = 1024,
    parameter  int SCAN_RATE      = 32,
    parameter  int BLANK_CYCLES   = 2,
    parameter  int ON_CYCLES      = 64,
    localparam int TW             = $clog2(ROTATIONAL_RES),
    localparam int AW             = $clog2(SCAN_RATE)
) (
    input  logic          clk_in,
    input  logic          rst_in,
    input  logic [TW-1:0] dtheta,
    output logic          fetch_req,
    output logic [AW-1:0] fetch_row,
    output logic [TW-1:0] fetch_theta,
    input  logic          fetch_valid,
    output logic          shift_valid,
    input  logic          shift_ready,
    input  logic          shift_done,
    output logic [AW-1:0] hub75_addr,
    output logic          hub75_latch,
    output logic          hub75_oe_n,
    output logic          frame_done,
    output logic          overrun
);

    localparam int OW = $clog2(ON_CYCLES + 1);
    localparam int BW = $clog2(BLANK_CYCLES + 1);

    localparam logic [OW-1:0] ON_LAST      = OW'(ON_CYCLES);
    localparam logic [BW-1:0] BLANK_LAST   = BW'(BLANK_CYCLES);
    localparam logic [BW-1:0] BLANK_PENULT = BW'(BLANK_CYCLES - 1);
    localparam logic [AW-1:0] ROW_LAST     = AW'(SCAN_RATE - 1);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        SHIFT,
        WAIT_DONE,
        BLANK,
        LATCH,
        DISPLAY
    } state_e;

    state_e        state_q;
    logic [TW-1:0] theta_q;
    logic [AW-1:0] row_q;
    logic          first_q;
    logic          pending_q;
    logic [BW-1:0] blank_cnt_q;
    logic [OW-1:0] on_cnt_q;

    logic          fetch_req_q;
    logic [AW-1:0] fetch_row_q;
    logic [TW-1:0] fetch_theta_q;
    logic          shift_valid_q;
    logic [AW-1:0] hub75_addr_q;
    logic          hub75_latch_q;
    logic          hub75_oe_n_q;
    logic          frame_done_q;
    logic          overrun_q;

    logic          theta_changed_d;
    logic          start_d;
    logic          overrun_d;

    assign theta_changed_d = (dtheta != theta_q);
    assign start_d         = first_q | pending_q | theta_changed_d;
    // Only the first mid-scan change of a scan is flagged; later ones are folded into pending.
    assign overrun_d       = (state_q != IDLE) && theta_changed_d && !pending_q;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q       <= IDLE;
            theta_q       <= '0;
            row_q         <= '0;
            first_q       <= 1'b1;
            pending_q     <= 1'b0;
            blank_cnt_q   <= '0;
            on_cnt_q      <= '0;
            fetch_req_q   <= 1'b0;
            fetch_row_q   <= '0;
            fetch_theta_q <= '0;
            shift_valid_q <= 1'b0;
            hub75_addr_q  <= '0;
            hub75_latch_q <= 1'b0;
            hub75_oe_n_q  <= 1'b1;
            frame_done_q  <= 1'b0;
            overrun_q     <= 1'b0;
        end else begin
            // NOTE: pulse outputs default low each cycle; a later assignment in this block wins.
            frame_done_q <= 1'b0;
            overrun_q    <= overrun_d;
            if (overrun_d) begin
                pending_q <= 1'b1;
            end

            case (state_q)
                IDLE: begin
                    if (start_d) begin
                        theta_q       <= dtheta;
                        row_q         <= '0;
                        first_q       <= 1'b0;
                        pending_q     <= 1'b0;
                        fetch_req_q   <= 1'b1;
                        fetch_row_q   <= '0;
                        fetch_theta_q <= dtheta;
                        state_q       <= FETCH;
                    end
                end

                FETCH: begin
                    if (fetch_valid) begin
                        fetch_req_q   <= 1'b0;
                        shift_valid_q <= 1'b1;
                        state_q       <= SHIFT;
                    end
                end

                SHIFT: begin
                    if (shift_ready) begin
                        shift_valid_q <= 1'b0;
                        state_q       <= WAIT_DONE;
                    end
                end

                WAIT_DONE: begin
                    if (shift_done) begin
                        blank_cnt_q <= BW'(1);
                        if (BLANK_CYCLES == 1) begin
                            hub75_addr_q <= row_q;
                        end
                        state_q <= BLANK;
                    end
                end

                BLANK: begin
                    // The address moves on the last blank cycle, well clear of latch and OE.
                    if (blank_cnt_q == BLANK_LAST) begin
                        hub75_latch_q <= 1'b1;
                        state_q       <= LATCH;
                    end else begin
                        blank_cnt_q <= blank_cnt_q + BW'(1);
                        if (blank_cnt_q == BLANK_PENULT) begin
                            hub75_addr_q <= row_q;
                        end
                    end
                end

                LATCH: begin
                    hub75_latch_q <= 1'b0;
                    hub75_oe_n_q  <= 1'b0;
                    on_cnt_q      <= OW'(1);
                    state_q       <= DISPLAY;
                end

                DISPLAY: begin
                    if (on_cnt_q == ON_LAST) begin
                        hub75_oe_n_q <= 1'b1;
                        if (row_q == ROW_LAST) begin
                            frame_done_q <= 1'b1;
                            state_q      <= IDLE;
                        end else begin
                            row_q       <= row_q + AW'(1);
                            fetch_req_q <= 1'b1;
                            fetch_row_q <= row_q + AW'(1);
                            state_q     <= FETCH;
                        end
                    end else begin
                        on_cnt_q <= on_cnt_q + OW'(1);
                    end
                end

                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign fetch_req   = fetch_req_q;
    assign fetch_row   = fetch_row_q;
    assign fetch_theta = fetch_theta_q;
    assign shift_valid = shift_valid_q;
    assign hub75_addr  = hub75_addr_q;
    assign hub75_latch = hub75_latch_q;
    assign hub75_oe_n  = hub75_oe_n_q;
    assign frame_done  = frame_done_q;
    assign overrun     = overrun_q;

endmodule

// File: tb/tb_hub75_scan_controller.sv
// Directed bench for hub75_scan_controller: full scans, per-row waveform,
// backpressure, mid-scan theta change, reset during display and idle hold.
module tb_hub75_scan_controller;

    localparam int TW = 10;
    localparam int AW = 5;
    localparam int SCAN_RATE = 32;
    localparam int ON_CYCLES = 64;

    logic          clk_in = 1'b0;
    logic          rst_in;
    logic [TW-1:0] dtheta;
    logic          fetch_req;
    logic [AW-1:0] fetch_row;
    logic [TW-1:0] fetch_theta;
    logic          fetch_valid;
    logic          shift_valid;
    logic          shift_ready;
    logic          shift_done;
    logic [AW-1:0] hub75_addr;
    logic          hub75_latch;
    logic          hub75_oe_n;
    logic          frame_done;
    logic          overrun;

    int checks = 0;
    int passed = 0;
    int fails  = 0;

    int fd_count = 0;
    int ov_count = 0;
    int viol     = 0;
    logic [AW-1:0] mon_prev_addr = '0;

    hub75_scan_controller #(
        .ROTATIONAL_RES(1024),
        .SCAN_RATE     (SCAN_RATE),
        .BLANK_CYCLES  (2),
        .ON_CYCLES     (ON_CYCLES)
    ) dut (
        .clk_in      (clk_in),
        .rst_in      (rst_in),
        .dtheta      (dtheta),
        .fetch_req   (fetch_req),
        .fetch_row   (fetch_row),
        .fetch_theta (fetch_theta),
        .fetch_valid (fetch_valid),
        .shift_valid (shift_valid),
        .shift_ready (shift_ready),
        .shift_done  (shift_done),
        .hub75_addr  (hub75_addr),
        .hub75_latch (hub75_latch),
        .hub75_oe_n  (hub75_oe_n),
        .frame_done  (frame_done),
        .overrun     (overrun)
    );

    always #5 clk_in = ~clk_in;

    // Pulse counters and the "address stable while lit" watchdog.
    always @(negedge clk_in) begin
        if (frame_done === 1'b1) fd_count = fd_count + 1;
        if (overrun === 1'b1) ov_count = ov_count + 1;
        if ((hub75_addr !== mon_prev_addr) && (hub75_oe_n !== 1'b1 || hub75_latch === 1'b1))
            viol = viol + 1;
        mon_prev_addr = hub75_addr;
    end

    task automatic tick();
        @(negedge clk_in);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks = checks + 1;
        assert (obs === exp) passed = passed + 1;
        else begin
            fails = fails + 1;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One row from FETCH through DISPLAY; entered and left on a negedge where
    // the FETCH request (or frame_done) is visible.
    task automatic do_row(input int row, input int theta, input int prev_addr,
                          input int fwait, input int rwait,
                          input bit chg, input bit stray, input bit abort);
        int lit;
        check("fetch_req", 32'(fetch_req), 1);
        check("fetch_row", 32'(fetch_row), row);
        check("fetch_theta", 32'(fetch_theta), theta);
        for (int i = 0; i < fwait; i++) begin
            if (chg) dtheta = (i == 0) ? 10'd6 : 10'd7;
            if (stray) shift_done = (i == 1);
            tick();
            shift_done = 1'b0;
            check("fetch_hold_req", 32'(fetch_req), 1);
            check("fetch_hold_row", 32'(fetch_row), row);
            check("fetch_hold_sv", 32'(shift_valid), 0);
            check("fetch_hold_oe", 32'(hub75_oe_n), 1);
            check("fetch_hold_addr", 32'(hub75_addr), prev_addr);
            if (chg) check("overrun_pulse", 32'(overrun), (i == 0) ? 1 : 0);
        end
        fetch_valid = 1'b1;
        tick();
        fetch_valid = 1'b0;
        check("fetch_drop", 32'(fetch_req), 0);
        check("shift_valid_up", 32'(shift_valid), 1);
        for (int i = 0; i < rwait; i++) begin
            shift_ready = 1'b0;
            tick();
            check("shift_hold_sv", 32'(shift_valid), 1);
            check("shift_hold_oe", 32'(hub75_oe_n), 1);
            check("shift_hold_addr", 32'(hub75_addr), prev_addr);
        end
        shift_ready = 1'b1;
        tick();
        shift_ready = 1'b0;
        check("shift_valid_down", 32'(shift_valid), 0);
        tick();
        shift_done = 1'b1;
        tick();
        shift_done = 1'b0;
        check("blank1_oe", 32'(hub75_oe_n), 1);
        check("blank1_addr", 32'(hub75_addr), prev_addr);
        check("blank1_latch", 32'(hub75_latch), 0);
        tick();
        check("blank2_oe", 32'(hub75_oe_n), 1);
        check("blank2_addr", 32'(hub75_addr), row);
        check("blank2_latch", 32'(hub75_latch), 0);
        tick();
        check("latch_strobe", 32'(hub75_latch), 1);
        check("latch_oe", 32'(hub75_oe_n), 1);
        check("latch_addr", 32'(hub75_addr), row);
        lit = 0;
        for (int i = 0; i < ON_CYCLES; i++) begin
            tick();
            if (abort && i == 10) begin
                rst_in = 1'b1;
                tick();
                rst_in = 1'b0;
                check("rst_oe", 32'(hub75_oe_n), 1);
                check("rst_addr", 32'(hub75_addr), 0);
                check("rst_latch", 32'(hub75_latch), 0);
                check("rst_fetch_req", 32'(fetch_req), 0);
                check("rst_shift_valid", 32'(shift_valid), 0);
                return;
            end
            if (hub75_oe_n === 1'b0 && hub75_latch === 1'b0) lit = lit + 1;
        end
        check("on_time", lit, ON_CYCLES);
        tick();
        check("post_on_oe", 32'(hub75_oe_n), 1);
        if (row == SCAN_RATE - 1) begin
            check("frame_done_pulse", 32'(frame_done), 1);
            check("last_no_fetch", 32'(fetch_req), 0);
        end else begin
            check("no_frame_done", 32'(frame_done), 0);
        end
    endtask

    initial begin
        int idle_ok;
        rst_in      = 1'b1;
        dtheta      = 10'd5;
        fetch_valid = 1'b0;
        shift_ready = 1'b0;
        shift_done  = 1'b0;
        repeat (3) tick();
        check("reset_oe", 32'(hub75_oe_n), 1);
        check("reset_addr", 32'(hub75_addr), 0);
        check("reset_latch", 32'(hub75_latch), 0);
        check("reset_fetch_req", 32'(fetch_req), 0);
        check("reset_shift_valid", 32'(shift_valid), 0);
        check("reset_frame_done", 32'(frame_done), 0);
        check("reset_overrun", 32'(overrun), 0);

        rst_in = 1'b0;
        tick();
        // Scan 1: theta 5, backpressure on row 3, theta 5->6->7 during row 10.
        for (int r = 0; r < SCAN_RATE; r++) begin
            do_row(r, 5, (r == 0) ? 0 : r - 1,
                   (r == 3) ? 7 : ((r == 10) ? 2 : 0), (r == 3) ? 5 : 0,
                   r == 10, 1'b0, 1'b0);
        end
        tick();
        check("scan2_fetch_req", 32'(fetch_req), 1);
        check("scan2_theta", 32'(fetch_theta), 7);
        check("scan2_row", 32'(fetch_row), 0);
        check("frame_done_clear", 32'(frame_done), 0);
        check("scan1_frame_done_count", fd_count, 1);
        check("scan1_overrun_count", ov_count, 1);

        // Scan 2: theta 7, reset during DISPLAY of row 12.
        for (int r = 0; r <= 12; r++) begin
            do_row(r, 7, (r == 0) ? 31 : r - 1, 0, 0, 1'b0, 1'b0, r == 12);
        end
        tick();
        check("fresh_fetch_req", 32'(fetch_req), 1);
        check("fresh_row", 32'(fetch_row), 0);
        check("fresh_theta", 32'(fetch_theta), 7);

        // Scan 3: theta 7 again, stray shift_done during FETCH of row 4.
        for (int r = 0; r < SCAN_RATE; r++) begin
            do_row(r, 7, (r == 0) ? 0 : r - 1, (r == 4) ? 3 : 0, 0,
                   1'b0, r == 4, 1'b0);
        end
        idle_ok = 0;
        repeat (20) begin
            tick();
            if (fetch_req === 1'b0 && hub75_oe_n === 1'b1 && frame_done === 1'b0)
                idle_ok = idle_ok + 1;
        end
        check("idle_hold", idle_ok, 20);
        check("total_frame_done_count", fd_count, 2);
        check("total_overrun_count", ov_count, 1);
        check("addr_stable_while_lit", viol, 0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
